// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: store-and-forward AXI-Stream packet FIFO that exposes only complete packets.
// Ports:
//   aclk, aresetn (sync, active-low)
//   s_axis_*        slave beat in, s_axis_tready registered
//   drop_incmpt_pkt abort the packet currently being written
//   m_axis_*        registered master beat out
//   pkt_cnt         complete packets held, fill_level entries written minus entries delivered
//   drop_cnt        saturating dropped-packet count, overflow pulses once per no-space drop
module axis_pkt_fifo #(
  parameter int C_DATA_WIDTH = 256,
  parameter int C_MTY_WIDTH = 5,
  parameter int C_MAX_DEPTH_BITS = 9,
  parameter int C_DROP_CNT_WIDTH = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        s_axis_tvalid,
  input  logic [C_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                        s_axis_tlast,
  input  logic [C_MTY_WIDTH-1:0]      s_axis_tuser_mty,
  output logic                        s_axis_tready,
  input  logic                        drop_incmpt_pkt,
  output logic                        m_axis_tvalid,
  output logic [C_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                        m_axis_tlast,
  output logic [C_MTY_WIDTH-1:0]      m_axis_tuser_mty,
  input  logic                        m_axis_tready,
  output logic [C_MAX_DEPTH_BITS:0]   pkt_cnt,
  output logic [C_MAX_DEPTH_BITS:0]   fill_level,
  output logic [C_DROP_CNT_WIDTH-1:0] drop_cnt,
  output logic                        overflow
);
  localparam int N = C_MAX_DEPTH_BITS;
  localparam int EW = C_DATA_WIDTH + 1 + C_MTY_WIDTH;
  typedef logic [N:0] ptr_t;
  typedef logic [C_DROP_CNT_WIDTH-1:0] dcnt_t;
  typedef enum logic {PASS, DISCARD} wstate_t;
  wstate_t state;
  ptr_t wr_cur, wr_commit, rd_p, rd_f, used;
  logic [EW-1:0] mem [1<<N];
  logic [EW-1:0] ram_q;
  logic [EW-1:0] sk [2];
  logic [1:0] sk_n;
  logic sk_h, rq_v;
  logic acc, space, abort, wr_en, commit, ovf_drop, pop, pop_last, rd_en, sk_pop;
  logic [2:0] occ;
  // rd_p advances only on master handshakes, so prefetched beats still occupy space;
  // rd_f is the RAM fetch pointer and never passes wr_commit.
  assign used = wr_cur - rd_p;
  assign space = !used[N];
  assign fill_level = used;
  assign acc = s_axis_tvalid && s_axis_tready;
  assign abort = state == PASS && drop_incmpt_pkt && (wr_cur != wr_commit || acc);
  assign wr_en = state == PASS && acc && space && !abort;
  assign commit = wr_en && s_axis_tlast;
  assign ovf_drop = state == PASS && acc && !space && !abort;
  assign pop = m_axis_tvalid && m_axis_tready;
  assign pop_last = pop && m_axis_tlast;
  // Beats held after this edge (output reg + skid + RAM read in flight) may not exceed 3.
  assign occ = 3'(m_axis_tvalid) + 3'(sk_n) + 3'(rq_v) - 3'(pop);
  assign rd_en = rd_f != wr_commit && occ < 3'd3;
  assign sk_pop = sk_n != 2'd0 && (!m_axis_tvalid || m_axis_tready);
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_cur[N-1:0]] <= {s_axis_tdata, s_axis_tlast, s_axis_tuser_mty};
    if (rd_en) ram_q <= mem[rd_f[N-1:0]];
    // With two entries held, a pop is guaranteed this cycle, so the tail slot is the head slot.
    if (rq_v) sk[sk_h ^ sk_n[0]] <= ram_q;
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= PASS;
      wr_cur <= '0;
      wr_commit <= '0;
      s_axis_tready <= 1'b0;
      pkt_cnt <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
      overflow <= ovf_drop;
      pkt_cnt <= pkt_cnt + ptr_t'(commit) - ptr_t'(pop_last);
      if (abort || ovf_drop) begin
        wr_cur <= wr_commit;
        drop_cnt <= drop_cnt == '1 ? drop_cnt : drop_cnt + dcnt_t'(1);
        state <= acc && s_axis_tlast ? PASS : DISCARD;
      end else begin
        if (wr_en) wr_cur <= wr_cur + ptr_t'(1);
        if (state == DISCARD && acc && s_axis_tlast) state <= PASS;
      end
      if (commit) wr_commit <= wr_cur + ptr_t'(1);
    end
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_p <= '0;
      rd_f <= '0;
      rq_v <= 1'b0;
      sk_n <= '0;
      sk_h <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tuser_mty <= '0;
    end else begin
      rq_v <= rd_en;
      if (rd_en) rd_f <= rd_f + ptr_t'(1);
      if (pop) rd_p <= rd_p + ptr_t'(1);
      sk_n <= sk_n + 2'(rq_v) - 2'(sk_pop);
      if (sk_pop) begin
        sk_h <= ~sk_h;
        {m_axis_tdata, m_axis_tlast, m_axis_tuser_mty} <= sk[sk_h];
      end
      m_axis_tvalid <= sk_pop || (m_axis_tvalid && !m_axis_tready);
    end
  end
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb_axis_pkt_fifo: directed-vector and scoreboard bench for axis_pkt_fifo at depth 16.
module tb_axis_pkt_fifo;
  localparam int DW = 32, MW = 5, NB = 4, CW = 4, D = 16;
  typedef logic [DW+MW:0] beat_t;
  typedef struct {
    logic v, l;
    logic [DW-1:0] d;
    logic [MW-1:0] m;
    logic drp, rdy;
    logic ev, el;
    logic [DW-1:0] ed;
    logic [MW-1:0] em;
    int epk, efl, edc;
    logic eov;
  } vec_t;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready, drop_incmpt_pkt = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0, m_axis_tdata;
  logic [MW-1:0] s_axis_tuser_mty = '0, m_axis_tuser_mty;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b0, overflow;
  logic [NB:0] pkt_cnt, fill_level;
  logic [CW-1:0] drop_cnt;
  int checks = 0, errors = 0;
  beat_t exp_q[$], rcv_q[$], m_pend[$];
  int m_rd = 0, ovf_n = 0, m_cur = 0, m_com = 0, m_drops = 0;
  bit m_disc = 0, rnd_rdy = 0, prev_stall = 0;
  beat_t prev_beat;
  vec_t tv[11];
  always #5 aclk = ~aclk;
  axis_pkt_fifo #(.C_DATA_WIDTH(DW), .C_MTY_WIDTH(MW), .C_MAX_DEPTH_BITS(NB), .C_DROP_CNT_WIDTH(CW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser_mty(s_axis_tuser_mty), .s_axis_tready(s_axis_tready), .drop_incmpt_pkt(drop_incmpt_pkt),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser_mty(m_axis_tuser_mty), .m_axis_tready(m_axis_tready),
    .pkt_cnt(pkt_cnt), .fill_level(fill_level), .drop_cnt(drop_cnt), .overflow(overflow)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Output monitor: records delivered beats, counts overflow pulses, checks stall stability.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (prev_stall) begin
        checks++;
        if (!m_axis_tvalid || {m_axis_tdata, m_axis_tlast, m_axis_tuser_mty} !== prev_beat) begin
          errors++;
          $display("FAIL stall_hold: got %0h expected %0h", {m_axis_tdata, m_axis_tlast, m_axis_tuser_mty}, prev_beat);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        rcv_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser_mty});
        m_rd++;
      end
      if (overflow) ovf_n++;
    end
    prev_stall = aresetn && m_axis_tvalid && !m_axis_tready;
    prev_beat = {m_axis_tdata, m_axis_tlast, m_axis_tuser_mty};
  end
  // Reference behaviour of the write side, evaluated for the beat presented at the next edge.
  task automatic model(input bit v, input bit last, input logic [DW-1:0] d, input logic [MW-1:0] mty, input bit drp);
    if (!m_disc && drp && (m_cur != m_com || v)) begin
      m_cur = m_com;
      m_pend.delete();
      m_drops++;
      m_disc = !(v && last);
    end else if (v && m_disc) begin
      if (last) m_disc = 0;
    end else if (v && m_cur - m_rd < D) begin
      m_pend.push_back({d, last, mty});
      m_cur++;
      if (last) begin
        foreach (m_pend[i]) exp_q.push_back(m_pend[i]);
        m_pend.delete();
        m_com = m_cur;
      end
    end else if (v) begin
      m_cur = m_com;
      m_pend.delete();
      m_drops++;
      m_disc = !last;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      if (rnd_rdy) m_axis_tready = 1'($urandom_range(0, 1));
      @(posedge aclk);
      #1;
    end
  endtask
  task automatic beat(input bit v, input bit last, input logic [DW-1:0] d, input logic [MW-1:0] mty, input bit drp);
    s_axis_tvalid = v;
    s_axis_tlast = last;
    s_axis_tdata = d;
    s_axis_tuser_mty = mty;
    drop_incmpt_pkt = drp;
    model(v, last, d, mty, drp);
    idle(1);
    s_axis_tvalid = 1'b0;
    drop_incmpt_pkt = 1'b0;
  endtask
  task automatic pkt_beat(input int id, input int b, input int len, input bit drp);
    logic [15:0] i16, b16;
    logic [MW-1:0] mty;
    i16 = id[15:0];
    b16 = b[15:0];
    mty = b == len - 1 ? MW'(id % 32) : '0;
    beat(1'b1, b == len - 1, {i16, b16}, mty, drp);
  endtask
  task automatic send_pkt(input int id, input int len);
    for (int b = 0; b < len; b++) pkt_beat(id, b, len, 1'b0);
  endtask
  task automatic do_reset();
    aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    drop_incmpt_pkt = 1'b0;
    exp_q.delete();
    rcv_q.delete();
    m_pend.delete();
    {m_rd, ovf_n, m_cur, m_com, m_drops, m_disc} = '0;
    @(posedge aclk);
    #1;
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_m_mty", m_axis_tuser_mty, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_overflow", overflow, 0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("rst_release_tready", s_axis_tready, 1);
  endtask
  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (rcv_q.size() < exp_q.size() && n < budget) begin
      idle(1);
      n++;
    end
    idle(8);
    chk({nm, "_beats"}, rcv_q.size(), exp_q.size());
    n = 0;
    for (int i = 0; i < rcv_q.size() && i < exp_q.size(); i++)
      if (rcv_q[i] !== exp_q[i]) begin
        if (n == 0) $display("first difference in %s at beat %0d: got %0h expected %0h", nm, i, rcv_q[i], exp_q[i]);
        n++;
      end
    chk({nm, "_data"}, n, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tv[0]  = '{1, 0, 32'hA0, 0, 0, 1,  0, 0, 0, 0,      0, 1, 0, 0};
    tv[1]  = '{1, 0, 32'hA1, 0, 0, 1,  0, 0, 0, 0,      0, 2, 0, 0};
    tv[2]  = '{1, 0, 32'hA2, 0, 0, 1,  0, 0, 0, 0,      0, 3, 0, 0};
    tv[3]  = '{1, 1, 32'hA3, 5, 0, 1,  0, 0, 0, 0,      1, 4, 0, 0};
    tv[4]  = '{0, 0, 0,      0, 0, 1,  0, 0, 0, 0,      1, 4, 0, 0};
    tv[5]  = '{0, 0, 0,      0, 0, 1,  0, 0, 0, 0,      1, 4, 0, 0};
    tv[6]  = '{0, 0, 0,      0, 0, 1,  1, 0, 32'hA0, 0, 1, 4, 0, 0};
    tv[7]  = '{0, 0, 0,      0, 0, 1,  1, 0, 32'hA1, 0, 1, 3, 0, 0};
    tv[8]  = '{0, 0, 0,      0, 0, 1,  1, 0, 32'hA2, 0, 1, 2, 0, 0};
    tv[9]  = '{0, 0, 0,      0, 0, 1,  1, 1, 32'hA3, 5, 1, 1, 0, 0};
    tv[10] = '{0, 0, 0,      0, 0, 1,  0, 0, 0, 0,      0, 0, 0, 0};
    do_reset();
    // Single 4-beat packet: first beat appears three edges after the tlast edge.
    foreach (tv[i]) begin
      s_axis_tvalid = tv[i].v;
      s_axis_tlast = tv[i].l;
      s_axis_tdata = tv[i].d;
      s_axis_tuser_mty = tv[i].m;
      drop_incmpt_pkt = tv[i].drp;
      m_axis_tready = tv[i].rdy;
      @(posedge aclk);
      #1;
      chk($sformatf("vec%0d_tvalid", i), m_axis_tvalid, tv[i].ev);
      chk($sformatf("vec%0d_pkt_cnt", i), pkt_cnt, tv[i].epk);
      chk($sformatf("vec%0d_fill", i), fill_level, tv[i].efl);
      chk($sformatf("vec%0d_drop_cnt", i), drop_cnt, tv[i].edc);
      chk($sformatf("vec%0d_overflow", i), overflow, tv[i].eov);
      if (tv[i].ev) begin
        chk($sformatf("vec%0d_tdata", i), m_axis_tdata, tv[i].ed);
        chk($sformatf("vec%0d_tlast", i), m_axis_tlast, tv[i].el);
        chk($sformatf("vec%0d_mty", i), m_axis_tuser_mty, tv[i].em);
      end
    end
    s_axis_tvalid = 1'b0;
    // Overflow: two 6-beat packets fit, the third runs out of space on its fifth beat.
    do_reset();
    m_axis_tready = 1'b0;
    send_pkt(1, 6);
    send_pkt(2, 6);
    chk("ovf_pkt_cnt2", pkt_cnt, 2);
    chk("ovf_fill12", fill_level, 12);
    for (int b = 0; b < 6; b++) begin
      pkt_beat(3, b, 6, 1'b0);
      if (b == 3) begin
        chk("ovf_full_fill16", fill_level, 16);
        chk("ovf_last_fit_no_pulse", overflow, 0);
      end
      if (b == 4) begin
        chk("ovf_pulse", overflow, 1);
        chk("ovf_drop_cnt", drop_cnt, 1);
        chk("ovf_rewind_fill", fill_level, 12);
      end
      if (b == 5) chk("ovf_pulse_end", overflow, 0);
    end
    chk("ovf_pkt_cnt", pkt_cnt, 2);
    chk("ovf_pulses", ovf_n, 1);
    m_axis_tready = 1'b1;
    drain("ovf", 200);
    chk("ovf_pkt_cnt_end", pkt_cnt, 0);
    chk("ovf_fill_end", fill_level, 0);
    // Full boundary: a pop at the same edge does not make room for an incoming beat.
    do_reset();
    m_axis_tready = 1'b0;
    send_pkt(4, 16);
    idle(4);
    chk("bnd_fill16", fill_level, 16);
    chk("bnd_tvalid", m_axis_tvalid, 1);
    m_axis_tready = 1'b1;
    pkt_beat(5, 0, 1, 1'b0);
    chk("bnd_overflow", overflow, 1);
    chk("bnd_fill15", fill_level, 15);
    chk("bnd_drop_cnt", drop_cnt, 1);
    send_pkt(6, 2);
    drain("bnd", 200);
    // Over-long packet is dropped; the next packet passes intact.
    do_reset();
    m_axis_tready = 1'b1;
    send_pkt(7, 20);
    chk("long_drop_cnt", drop_cnt, 1);
    chk("long_pulses", ovf_n, 1);
    chk("long_fill", fill_level, 0);
    chk("long_pkt_cnt", pkt_cnt, 0);
    send_pkt(8, 2);
    drain("long", 100);
    // Explicit abort on beat 3 of 6, then an abort with nothing in progress.
    do_reset();
    m_axis_tready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      pkt_beat(9, b, 6, b == 2);
      if (b == 2) begin
        chk("abort_drop_cnt", drop_cnt, 1);
        chk("abort_no_pulse", overflow, 0);
        chk("abort_fill", fill_level, 0);
      end
    end
    beat(1'b0, 1'b0, '0, '0, 1'b1);
    chk("abort_idle_ignored", drop_cnt, 1);
    send_pkt(10, 3);
    drain("abort", 100);
    chk("abort_pulses", ovf_n, 0);
    // Reset mid-packet with a committed packet already on the output.
    do_reset();
    m_axis_tready = 1'b0;
    send_pkt(11, 2);
    pkt_beat(12, 0, 4, 1'b0);
    pkt_beat(12, 1, 4, 1'b0);
    idle(3);
    chk("midrst_tvalid_before", m_axis_tvalid, 1);
    do_reset();
    m_axis_tready = 1'b1;
    idle(6);
    chk("midrst_no_stale", rcv_q.size(), 0);
    chk("midrst_tvalid_after", m_axis_tvalid, 0);
    send_pkt(13, 3);
    drain("midrst", 100);
    // Random traffic with 50% master ready and pointer wrap.
    do_reset();
    rnd_rdy = 1;
    for (int p = 0; p < 1000; p++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 4) == 0) idle(1);
        pkt_beat(100 + p, b, len, 1'b0);
      end
    end
    drain("rand", 5000);
    chk("rand_pulses", ovf_n, m_drops);
    chk("rand_drop_cnt_sat", drop_cnt, m_drops > 15 ? 15 : m_drops);
    chk("rand_pkt_cnt_end", pkt_cnt, 0);
    chk("rand_fill_end", fill_level, 0);
    rnd_rdy = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
